// File: rtl/spi_hex_uart_formatter_pkg.sv
// Shared types and ASCII helpers for the SPI-to-UART hex dump formatter.
package spi_hex_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HI,
        LO,
        SEP,
        CR,
        LF
    } state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;

    // Uppercase hex digit for one nibble.
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nibble);
        if (nibble <= 4'd9)
            return ASCII_0 + {4'h0, nibble};
        else
            return ASCII_A + {4'h0, nibble} - 8'd10;
    endfunction

endpackage

// File: rtl/spi_hex_uart_formatter_if.sv
// Bundle of the SPI receive handshake and UART TX FIFO write port seen by the formatter.
interface spi_hex_uart_formatter_if;

    logic [7:0] spi_rx_data;
    logic       spi_data_ready;
    logic       spi_read_ack;
    logic       tx_fifo_full;
    logic       tx_fifo_write_en;
    logic [7:0] tx_fifo_data_in;
    logic       busy;

    modport master (
        input  spi_rx_data,
        input  spi_data_ready,
        output spi_read_ack,
        input  tx_fifo_full,
        output tx_fifo_write_en,
        output tx_fifo_data_in,
        output busy
    );

    modport slave (
        output spi_rx_data,
        output spi_data_ready,
        input  spi_read_ack,
        output tx_fifo_full,
        input  tx_fifo_write_en,
        input  tx_fifo_data_in,
        input  busy
    );

endinterface

// File: rtl/spi_hex_uart_formatter.sv
// Turns each SPI byte into two hex characters plus separator (CR LF at line end) for the UART.
// Optional partial-line flush on idle timeout when SPI_HEX_FLUSH_EN is defined.
module spi_hex_uart_formatter
    import spi_hex_pkg::*;
#(
    parameter int         BYTES_PER_LINE = 16,
    parameter logic [7:0] SEPARATOR      = 8'h20,
    parameter int         FLUSH_CYCLES   = 2700000
) (
    input  logic                    system_clk,
    input  logic                    reset,
    spi_hex_uart_formatter_if.master bus
);

    localparam logic [7:0] LAST_IN_LINE = 8'(BYTES_PER_LINE - 1);

    state_t     state;
    state_t     next_state;
    logic [7:0] data_byte;
    logic [7:0] line_count;
    logic       armed;
    logic       capture;
    logic       can_write;
    logic       end_of_line;
    logic       flush_timeout;

    logic       ack_q;
    logic       write_q;
    logic [7:0] char_q;
    logic       busy_q;
    logic       ack_d;
    logic       write_d;
    logic [7:0] char_d;
    logic       busy_d;

    assign capture     = (state == IDLE) && bus.spi_data_ready && armed;
    // Never write on back-to-back cycles so the registered full flag is current.
    assign can_write   = !bus.tx_fifo_full && !write_q;
    assign end_of_line = (line_count == LAST_IN_LINE);

`ifdef SPI_HEX_FLUSH_EN
    localparam int IDLE_W = $clog2(FLUSH_CYCLES + 1);

    logic [IDLE_W-1:0] idle_count;

    assign flush_timeout = (state == IDLE) && (line_count != 8'd0) && !capture &&
                           (idle_count == IDLE_W'(FLUSH_CYCLES - 1));

    always_ff @(posedge system_clk) begin
        if (reset || capture || flush_timeout || state != IDLE || line_count == 8'd0)
            idle_count <= '0;
        else
            idle_count <= idle_count + 1'b1;
    end
`else
    logic unused_flush_cycles;

    assign flush_timeout       = 1'b0;
    assign unused_flush_cycles = |FLUSH_CYCLES;
`endif

    always_ff @(posedge system_clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (capture)
                    next_state = HI;
                else if (flush_timeout)
                    next_state = CR;
            end
            HI:  if (can_write) next_state = LO;
            LO:  if (can_write) next_state = end_of_line ? CR : SEP;
            SEP: if (can_write) next_state = IDLE;
            CR:  if (can_write) next_state = LF;
            LF:  if (can_write) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ack_d   = capture;
        write_d = (state != IDLE) && can_write;
        busy_d  = (next_state != IDLE);
        char_d  = char_q;
        case (state)
            HI:      char_d = nibble_to_ascii(data_byte[7:4]);
            LO:      char_d = nibble_to_ascii(data_byte[3:0]);
            SEP:     char_d = SEPARATOR;
            CR:      char_d = ASCII_CR;
            LF:      char_d = ASCII_LF;
            default: char_d = char_q;
        endcase
        if (!write_d)
            char_d = char_q;
    end

    // armed blocks re-capture of the same byte until upstream drops ready.
    always_ff @(posedge system_clk) begin
        if (reset) begin
            ack_q      <= 1'b0;
            write_q    <= 1'b0;
            char_q     <= 8'h00;
            busy_q     <= 1'b0;
            data_byte  <= 8'h00;
            line_count <= 8'd0;
            armed      <= 1'b1;
        end else begin
            ack_q   <= ack_d;
            write_q <= write_d;
            char_q  <= char_d;
            busy_q  <= busy_d;
            if (capture)
                data_byte <= bus.spi_rx_data;
            if (!bus.spi_data_ready)
                armed <= 1'b1;
            else if (capture)
                armed <= 1'b0;
            if (state == LO && can_write)
                line_count <= end_of_line ? 8'd0 : line_count + 8'd1;
            else if (flush_timeout)
                line_count <= 8'd0;
        end
    end

    assign bus.spi_read_ack     = ack_q;
    assign bus.tx_fifo_write_en = write_q;
    assign bus.tx_fifo_data_in  = char_q;
    assign bus.busy             = busy_q;

endmodule
